siso_frame_ctrl: RTL and testbench

SISO_FRAME_CTRL -- requirements
Module: siso_frame_ctrl

---
 rtl/siso_pkg.sv | 19 +
 rtl/shift_reg_load.sv | 48 ++++
 rtl/siso_frame_ctrl.sv | 104 ++++++++++
 tb/tb_siso_frame_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/siso_pkg.sv
// Shared types and defaults for the serial frame controller.
// Holds the FSM state enum, default frame geometry and a counter-width helper.
package siso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_GAP   = 2;

    // Width needed to count 0..n-1, never narrower than one bit.
    function automatic int cnt_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_reg_load.sv
// Parallel-load shift register with a registered head-bit output.
// The head flop is loaded with the bit that becomes the head, so it leads the register by nothing.
module shift_reg_load #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] load_data,
    output logic             head
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_shifted;
    logic             load_head;
    logic             next_head;

    generate
        if (MSB_FIRST) begin : g_msb
            assign load_head = load_data[WIDTH-1];
            assign next_head = q[WIDTH-2];
            assign q_shifted = {q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign load_head = load_data[0];
            assign next_head = q[1];
            assign q_shifted = {1'b0, q[WIDTH-1:1]};
        end
    endgenerate

    // Head is forced low whenever neither loading nor shifting, so it reads 0 outside a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            head <= 1'b0;
        end else if (load) begin
            q    <= load_data;
            head <= load_head;
        end else if (shift_en) begin
            q    <= q_shifted;
            head <= next_head;
        end else begin
            head <= 1'b0;
        end
    end

endmodule

// File: rtl/siso_frame_ctrl.sv
// Parallel-in serial-out frame controller: accepts a word in IDLE, shifts it out
// over WIDTH cycles, pulses done, then idles for GAP cycles before accepting again.
module siso_frame_ctrl
    import siso_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int GAP       = DEFAULT_GAP,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             so,
    output logic             so_en,
    output logic             done
);

    localparam int BW = cnt_bits(WIDTH);
    localparam int GW = cnt_bits(GAP + 1);
    localparam logic [BW-1:0] BIT_LOAD = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

    state_t          state;
    state_t          state_nxt;
    logic [BW-1:0]   bit_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            accept;
    logic            shift_en;
    logic            last_bit;
    logic            so_en_nxt;
    logic            done_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (din_valid) state_nxt = ST_SHIFT;
            ST_SHIFT: if (bit_cnt == '0) state_nxt = (GAP > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:   if (gap_cnt == '0) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // so_en and done are computed one cycle ahead here and registered below.
    always_comb begin
        din_ready = (state == ST_IDLE);
        accept    = din_ready && din_valid;
        last_bit  = (state == ST_SHIFT) && (bit_cnt == '0);
        shift_en  = (state == ST_SHIFT) && (bit_cnt != '0);
        so_en_nxt = (state_nxt == ST_SHIFT);
        done_nxt  = last_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            so_en <= 1'b0;
            done  <= 1'b0;
        end else begin
            so_en <= so_en_nxt;
            done  <= done_nxt;
        end
    end

    // Both counters only decrement while non-zero, so neither can wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            if (accept) begin
                bit_cnt <= BIT_LOAD;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt - BW'(1);
            end
            if (last_bit) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == ST_GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - GW'(1);
            end
        end
    end

    shift_reg_load #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .shift_en  (shift_en),
        .load_data (din),
        .head      (so)
    );

endmodule

// File: tb/tb_siso_frame_ctrl.sv
// Bench for siso_frame_ctrl: three configurations (MSB/GAP=2, LSB/GAP=2, MSB/GAP=0)
// checked every cycle against a frame-timeline model derived from the accept cycle.
module tb_siso_frame_ctrl;

    localparam int W = 8;
    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din       [N];
    logic         din_valid [N];
    logic         din_ready [N];
    logic         so        [N];
    logic         so_en     [N];
    logic         done      [N];

    logic [W-1:0] fw       [N];
    int           fstart   [N];
    int           done_at  [N];
    int           ready_at [N];
    int           cyc;
    int           checks;
    int           errors;

    always #5 clk = ~clk;

    siso_frame_ctrl #(.WIDTH(W), .GAP(2), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .din(din[0]), .din_valid(din_valid[0]),
        .din_ready(din_ready[0]), .so(so[0]), .so_en(so_en[0]), .done(done[0]));

    siso_frame_ctrl #(.WIDTH(W), .GAP(2), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .din(din[1]), .din_valid(din_valid[1]),
        .din_ready(din_ready[1]), .so(so[1]), .so_en(so_en[1]), .done(done[1]));

    siso_frame_ctrl #(.WIDTH(W), .GAP(0), .MSB_FIRST(1'b1)) dut_nogap (
        .clk(clk), .rst(rst), .din(din[2]), .din_valid(din_valid[2]),
        .din_ready(din_ready[2]), .so(so[2]), .so_en(so_en[2]), .done(done[2]));

    function automatic int gap_of(input int i);
        return (i == 2) ? 0 : 2;
    endfunction

    function automatic bit msb_of(input int i);
        return (i != 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            fstart[i]   = -1000;
            done_at[i]  = -1000;
            ready_at[i] = -1000;
        end
    endtask

    task automatic check_bit(input string tag, input int i, input logic got, input logic want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("[TB] FAIL %s[%0d] cycle %0d: observed %b expected %b", tag, i, cyc, got, want);
        end
    endtask

    // Expected outputs follow from the accept cycle: bits, then done, then GAP idle cycles.
    task automatic check_output();
        int   k;
        logic exp_so;
        logic exp_en;
        for (int i = 0; i < N; i++) begin
            k      = cyc - fstart[i];
            exp_en = (k >= 0) && (k < W);
            exp_so = 1'b0;
            if (exp_en) exp_so = msb_of(i) ? fw[i][W-1-k] : fw[i][k];
            check_bit("so_en", i, so_en[i], exp_en);
            check_bit("so", i, so[i], exp_so);
            check_bit("done", i, done[i], cyc == done_at[i]);
            check_bit("din_ready", i, din_ready[i], cyc >= ready_at[i]);
        end
    endtask

    task automatic apply_stimulus(input int i, input logic valid, input logic [W-1:0] data);
        din_valid[i] = valid;
        din[i]       = data;
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (!rst && din_valid[i] && (cyc >= ready_at[i])) begin
                fw[i]       = din[i];
                fstart[i]   = cyc + 1;
                done_at[i]  = cyc + W + 1;
                ready_at[i] = cyc + W + 1 + gap_of(i);
            end
        end
        cyc++;
        @(negedge clk);
        check_output();
    endtask

    task automatic run(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    task automatic pulse_reset(input int hold);
        rst = 1'b1;
        model_reset();
        #1;
        check_output();
        run(hold);
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        for (int i = 0; i < N; i++) apply_stimulus(i, 1'b0, '0);
        model_reset();
        #1;
        check_output();
        run(2);
        rst = 1'b0;
        step();

        $display("[TB] A5 msb, 01 lsb, AA/55 back-to-back without gap");
        apply_stimulus(0, 1'b1, 8'hA5);
        apply_stimulus(1, 1'b1, 8'h01);
        apply_stimulus(2, 1'b1, 8'hAA);
        step();
        apply_stimulus(0, 1'b0, 8'h00);
        apply_stimulus(1, 1'b0, 8'h00);
        apply_stimulus(2, 1'b1, 8'h55);
        run(9);
        apply_stimulus(2, 1'b0, 8'h00);
        run(12);

        $display("[TB] FF then 00 with valid held, gap 2");
        apply_stimulus(0, 1'b1, 8'hFF);
        apply_stimulus(1, 1'b1, 8'h3C);
        step();
        apply_stimulus(0, 1'b1, 8'h00);
        apply_stimulus(1, 1'b0, 8'h00);
        run(12);
        apply_stimulus(0, 1'b0, 8'h00);
        run(10);

        $display("[TB] reset mid-frame of F0, then 81");
        apply_stimulus(0, 1'b1, 8'hF0);
        apply_stimulus(2, 1'b1, 8'h96);
        step();
        apply_stimulus(0, 1'b0, 8'h00);
        apply_stimulus(2, 1'b0, 8'h00);
        run(2);
        pulse_reset(2);
        step();
        apply_stimulus(0, 1'b1, 8'h81);
        step();
        apply_stimulus(0, 1'b0, 8'h00);
        run(12);

        $display("[TB] din disturbed during shift of C3");
        apply_stimulus(0, 1'b1, 8'hC3);
        step();
        for (int j = 0; j < 9; j++) begin
            apply_stimulus(0, j[0], 8'h00);
            step();
        end
        apply_stimulus(0, 1'b0, 8'h00);
        run(6);

        $display("[TB] randomized traffic");
        for (int j = 0; j < 400; j++) begin
            for (int i = 0; i < N; i++) begin
                apply_stimulus(i, $urandom_range(0, 3) != 0, W'($urandom));
            end
            if ($urandom_range(0, 59) == 0) begin
                pulse_reset($urandom_range(0, 2));
            end
            step();
        end
        for (int i = 0; i < N; i++) apply_stimulus(i, 1'b0, '0);
        run(14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
